wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 61 ++++++
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Purpose : bundles the writeback-stage write port and the decode-stage read
//           port of the integer/FP register file into one connection.
// Signals :
//   ValidW, RegWriteW, ResultSrcW, JumpW  - writeback slot valid and integer
//                                           write controls
//   FPRegWriteW, FPResultSrcW             - FP write controls
//   RD_W, FP_RD_W                         - destination indices
//   PCPlus4W, ALU_ResultW, ReadDataW,
//   FP_ALU_ResultW, FP_ReadDataW          - writeback data candidates
//   RS1_D, RS2_D, FRS1_D, FRS2_D, FRS3_D  - read indices from decode
//   RD1_D, RD2_D, FRD1_D, FRD2_D, FRD3_D  - read data back to decode
//   ResultW, FP_ResultW                   - selected writeback values
// Modports: master = pipeline side, slave = register file side.
// ---------------------------------------------------------------------------
interface wb_regfile_if;
    logic        ValidW;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic        JumpW;
    logic        FPRegWriteW;
    logic        FPResultSrcW;
    logic [4:0]  RD_W;
    logic [4:0]  FP_RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic [31:0] FP_ALU_ResultW;
    logic [31:0] FP_ReadDataW;
    logic [4:0]  RS1_D;
    logic [4:0]  RS2_D;
    logic [4:0]  FRS1_D;
    logic [4:0]  FRS2_D;
    logic [4:0]  FRS3_D;
    logic [31:0] RD1_D;
    logic [31:0] RD2_D;
    logic [31:0] FRD1_D;
    logic [31:0] FRD2_D;
    logic [31:0] FRD3_D;
    logic [31:0] ResultW;
    logic [31:0] FP_ResultW;

    modport master (
        output ValidW, RegWriteW, ResultSrcW, JumpW, FPRegWriteW, FPResultSrcW,
        output RD_W, FP_RD_W,
        output PCPlus4W, ALU_ResultW, ReadDataW, FP_ALU_ResultW, FP_ReadDataW,
        output RS1_D, RS2_D, FRS1_D, FRS2_D, FRS3_D,
        input  RD1_D, RD2_D, FRD1_D, FRD2_D, FRD3_D,
        input  ResultW, FP_ResultW
    );

    modport slave (
        input  ValidW, RegWriteW, ResultSrcW, JumpW, FPRegWriteW, FPResultSrcW,
        input  RD_W, FP_RD_W,
        input  PCPlus4W, ALU_ResultW, ReadDataW, FP_ALU_ResultW, FP_ReadDataW,
        input  RS1_D, RS2_D, FRS1_D, FRS2_D, FRS3_D,
        output RD1_D, RD2_D, FRD1_D, FRD2_D, FRD3_D,
        output ResultW, FP_ResultW
    );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Purpose : writeback stage plus 32x32 integer and 32x32 FP register files,
//           with a retired-instruction counter.
// Ports   :
//   clk         - clock, all state updates on its rising edge
//   rst         - asynchronous active-low reset; clears both files and the
//                 counter, blocks writes while low
//   wb          - wb_regfile_if.slave: writeback controls/data, read indices,
//                 read data and the selected writeback values
//   RetireCount - number of edges seen with ValidW high (wraps silently)
// Config  : define WB_REGFILE_BYPASS_EN to make a read of the register being
//           written in the same cycle return the value being written.
//           Without it, reads show the old contents until the next cycle.
// ---------------------------------------------------------------------------
module wb_regfile (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   wb,
    output logic [31:0]   RetireCount
);

    logic [31:0] int_regs [32];
    logic [31:0] fp_regs  [32];
    logic [31:0] retire_q;
    logic        int_we;
    logic        fp_we;

    // Writeback result selection; a jump's link value wins over the load/ALU choice.
    assign wb.ResultW    = wb.JumpW ? wb.PCPlus4W
                                    : (wb.ResultSrcW ? wb.ReadDataW : wb.ALU_ResultW);
    assign wb.FP_ResultW = wb.FPResultSrcW ? wb.FP_ReadDataW : wb.FP_ALU_ResultW;

    // rst is folded in so that a write held during reset cannot appear on
    // the bypass path either; x0 is excluded so it stays hard-wired to zero.
    assign int_we = rst & wb.ValidW & wb.RegWriteW & (wb.RD_W != 5'd0);
    assign fp_we  = rst & wb.ValidW & wb.FPRegWriteW;

    // Integer file: entry 0 is never written, so it keeps its reset zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                int_regs[i] <= '0;
            end
        end else if (int_we) begin
            int_regs[wb.RD_W] <= wb.ResultW;
        end
    end

    // FP file: f0 is an ordinary register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                fp_regs[i] <= '0;
            end
        end else if (fp_we) begin
            fp_regs[wb.FP_RD_W] <= wb.FP_ResultW;
        end
    end

    // Retire counter counts every valid writeback slot, write or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_q <= '0;
        end else if (wb.ValidW) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign RetireCount = retire_q;

    // Combinational read ports, optionally overridden by the in-flight write.
    always_comb begin
        wb.RD1_D  = (wb.RS1_D == 5'd0) ? 32'd0 : int_regs[wb.RS1_D];
        wb.RD2_D  = (wb.RS2_D == 5'd0) ? 32'd0 : int_regs[wb.RS2_D];
        wb.FRD1_D = fp_regs[wb.FRS1_D];
        wb.FRD2_D = fp_regs[wb.FRS2_D];
        wb.FRD3_D = fp_regs[wb.FRS3_D];
`ifdef WB_REGFILE_BYPASS_EN
        if (int_we && (wb.RS1_D == wb.RD_W)) wb.RD1_D = wb.ResultW;
        if (int_we && (wb.RS2_D == wb.RD_W)) wb.RD2_D = wb.ResultW;
        if (fp_we && (wb.FRS1_D == wb.FP_RD_W)) wb.FRD1_D = wb.FP_ResultW;
        if (fp_we && (wb.FRS2_D == wb.FP_RD_W)) wb.FRD2_D = wb.FP_ResultW;
        if (fp_we && (wb.FRS3_D == wb.FP_RD_W)) wb.FRD3_D = wb.FP_ResultW;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Purpose : directed, self-checking bench for wb_regfile. Expected values are
//           hand-computed constants; the same-cycle read expectations follow
//           WB_REGFILE_BYPASS_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] retire_count;
    int          checks;
    int          errors;

    wb_regfile_if bus();

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (bus.slave),
        .RetireCount (retire_count)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives the whole writeback side in one call.
    task automatic applyStimulus(
        input logic        valid,
        input logic        reg_write,
        input logic        result_src,
        input logic        jump,
        input logic        fp_reg_write,
        input logic        fp_result_src,
        input logic [4:0]  rd,
        input logic [4:0]  fp_rd,
        input logic [31:0] pc_plus4,
        input logic [31:0] alu,
        input logic [31:0] rdata,
        input logic [31:0] fp_alu,
        input logic [31:0] fp_rdata
    );
        bus.ValidW         = valid;
        bus.RegWriteW      = reg_write;
        bus.ResultSrcW     = result_src;
        bus.JumpW          = jump;
        bus.FPRegWriteW    = fp_reg_write;
        bus.FPResultSrcW   = fp_result_src;
        bus.RD_W           = rd;
        bus.FP_RD_W        = fp_rd;
        bus.PCPlus4W       = pc_plus4;
        bus.ALU_ResultW    = alu;
        bus.ReadDataW      = rdata;
        bus.FP_ALU_ResultW = fp_alu;
        bus.FP_ReadDataW   = fp_rdata;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic setReads(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] frs1, input logic [4:0] frs2,
                            input logic [4:0] frs3);
        bus.RS1_D  = rs1;
        bus.RS2_D  = rs2;
        bus.FRS1_D = frs1;
        bus.FRS2_D = frs2;
        bus.FRS3_D = frs3;
    endtask

    // Advance past one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_same_int;
        logic [31:0] exp_same_fp;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        setReads(5'd5, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();

        // Reset state and blocked writes while reset is held.
        checkOutput("reset_count", retire_count, 32'd0);
        checkOutput("reset_x5", bus.RD1_D, 32'd0);
        applyStimulus(1, 1, 0, 0, 1, 0, 5'd5, 5'd5, 32'd0, 32'hAAAA5555, 32'd0,
                      32'h1234ABCD, 32'd0);
        setReads(5'd5, 5'd0, 5'd5, 5'd0, 5'd0);
        #1;
        checkOutput("reset_resultw_comb", bus.ResultW, 32'hAAAA5555);
        checkOutput("reset_fpresultw_comb", bus.FP_ResultW, 32'h1234ABCD);
        tick();
        checkOutput("reset_blocked_x5", bus.RD1_D, 32'd0);
        checkOutput("reset_blocked_f5", bus.FRD1_D, 32'd0);
        checkOutput("reset_blocked_count", retire_count, 32'd0);
        idle();
        #2;
        rst = 1'b1;
        tick();

        // Basic ALU write to x5.
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd5, 5'd0, 32'd0, 32'h12345678, 32'd0, 32'd0, 32'd0);
        setReads(5'd5, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("x5_write", bus.RD1_D, 32'h12345678);
        checkOutput("count_after_x5", retire_count, 32'd1);

        // Write to x0 is discarded but still retires.
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
        setReads(5'd0, 5'd5, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("x0_bypass_blocked", bus.RD1_D, 32'd0);
        tick();
        idle();
        #1;
        checkOutput("x0_reads_zero", bus.RD1_D, 32'd0);
        checkOutput("x5_kept", bus.RD2_D, 32'h12345678);
        checkOutput("count_after_x0", retire_count, 32'd2);

        // Jump link value overrides ResultSrcW.
        applyStimulus(1, 1, 1, 1, 0, 0, 5'd1, 5'd0, 32'h104, 32'h66, 32'h55, 32'd0, 32'd0);
        setReads(5'd1, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        checkOutput("jump_resultw", bus.ResultW, 32'h104);
        tick();
        idle();
        #1;
        checkOutput("x1_link", bus.RD1_D, 32'h104);
        checkOutput("count_after_jump", retire_count, 32'd3);

        // Result mux legs without a write.
        applyStimulus(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 32'h104, 32'h66, 32'h55, 32'h77, 32'h88);
        #1;
        checkOutput("resultw_load", bus.ResultW, 32'h55);
        checkOutput("fpresultw_alu", bus.FP_ResultW, 32'h77);
        idle();

        // Simultaneous integer x3 and FP f3 writes.
        applyStimulus(1, 1, 0, 0, 1, 1, 5'd3, 5'd3, 32'd0, 32'h7, 32'd0, 32'h11, 32'h3F800000);
        setReads(5'd3, 5'd0, 5'd3, 5'd0, 5'd3);
`ifdef WB_REGFILE_BYPASS_EN
        exp_same_int = 32'h7;
        exp_same_fp  = 32'h3F800000;
`else
        exp_same_int = 32'd0;
        exp_same_fp  = 32'd0;
`endif
        #1;
        checkOutput("x3_same_cycle", bus.RD1_D, exp_same_int);
        checkOutput("f3_same_cycle", bus.FRD1_D, exp_same_fp);
        tick();
        idle();
        #1;
        checkOutput("x3_next_cycle", bus.RD1_D, 32'h7);
        checkOutput("f3_next_cycle", bus.FRD1_D, 32'h3F800000);
        checkOutput("f3_port3", bus.FRD3_D, 32'h3F800000);
        checkOutput("count_after_dual", retire_count, 32'd4);

        // f0 is writable.
        applyStimulus(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'hCAFEF00D, 32'd0);
        setReads(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        #1;
        checkOutput("f0_written", bus.FRD2_D, 32'hCAFEF00D);
        checkOutput("count_after_f0", retire_count, 32'd5);

        // ValidW=0 suppresses the write and the counter.
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd9, 5'd0, 32'd0, 32'h99, 32'd0, 32'd0, 32'd0);
        setReads(5'd0, 5'd9, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0, 5'd9, 5'd0, 32'd0, 32'hBAD, 32'd0, 32'd0, 32'd0);
        #1;
        checkOutput("invalid_no_bypass", bus.RD2_D, 32'h99);
        tick();
        idle();
        #1;
        checkOutput("x9_unchanged", bus.RD2_D, 32'h99);
        checkOutput("count_invalid", retire_count, 32'd6);

        // Counter wrap from all-ones.
        force dut.retire_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_q;
        #1;
        checkOutput("count_preload", retire_count, 32'hFFFFFFFF);
        applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        checkOutput("count_wrap", retire_count, 32'd0);

        // Mid-stream reset pulse clears everything immediately.
        setReads(5'd5, 5'd1, 5'd3, 5'd0, 5'd3);
        rst = 1'b0;
        #1;
        checkOutput("midrst_x5", bus.RD1_D, 32'd0);
        checkOutput("midrst_x1", bus.RD2_D, 32'd0);
        checkOutput("midrst_f3", bus.FRD1_D, 32'd0);
        checkOutput("midrst_f0", bus.FRD2_D, 32'd0);
        checkOutput("midrst_count", retire_count, 32'd0);
        #1;
        rst = 1'b1;

        // First edge after reset release behaves normally.
        applyStimulus(1, 1, 0, 0, 0, 0, 5'd5, 5'd0, 32'd0, 32'h77, 32'd0, 32'd0, 32'd0);
        tick();
        idle();
        #1;
        checkOutput("post_rst_x5", bus.RD1_D, 32'h77);
        checkOutput("post_rst_count", retire_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
